// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, one-shot or periodic
// auto-reload, and a sticky interrupt flag. Programmable delay/tick source.
module countdown_timer #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Load_en,
  input  logic [N-1:0] Data_in,
  input  logic         Count_en,
  input  logic         Mode,
  input  logic         Irq_clr,
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         Irq,
  output logic         Running,
  output logic         Done
);

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  logic [STATE_W-1:0] state_q, state_d;
  logic [N-1:0]       q_q, q_d;
  logic [N-1:0]       reload_q, reload_d;
  logic               tc_q, tc_d;
  logic               irq_q, irq_d;

  // Next-state and datapath: load beats counting; expiry is a full-width Q == 1.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (Load_en) begin
      reload_d = Data_in;
      q_d      = Data_in;
      state_d  = (Data_in != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Count_en) begin
            if (q_q == N'(1)) begin
              tc_d = 1'b1;
              if (Mode) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = ST_DONE;
              end
            end else if (q_q != '0) begin
              q_d = q_q - N'(1);
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Setting the flag wins over a same-edge clear.
    if (tc_d) begin
      irq_d = 1'b1;
    end else if (Irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      irq_q    <= irq_d;
    end
  end

  assign Q       = q_q;
  assign TC      = tc_q;
  assign Irq     = irq_q;
  assign Running = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable N-bit down-counter with terminal-count detection, one-shot or periodic auto-reload, and a sticky interrupt flag.
- Counterpart to the CPU's loadable up-counter. It counts the other way and reports expiry instead of free-running.
- Used as the CPU's programmable delay/tick source. The controller loads a period, then waits on TC or Irq.

Parameters:
N, 8, width of the count, reload and data registers

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset; highest priority
Load_en  input  1  load Data_in into both the Reload register and the counter
Data_in  input  N  load value (the period)
Count_en  input  1  decrement enable; low = pause
Mode  input  1  0 = one-shot, 1 = periodic auto-reload
Irq_clr  input  1  clear the sticky interrupt flag
Q  output  N  current count
TC  output  1  terminal-count pulse, registered, one cycle wide
Irq  output  1  sticky interrupt, set by TC
Running  output  1  1 when state = RUN
Done  output  1  1 when state = DONE (one-shot expired)

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. All outputs are registered or decoded from registered state.
- Reset values: Q = 0, Reload = 0, TC = 0, Irq = 0, state = IDLE (so Running = 0, Done = 0).
- States: IDLE, RUN, DONE.
- Priority per edge: RST > Load_en > counting. Irq_clr is evaluated independently, as described under Irq.
- Load_en = 1, any state:
  - Reload <= Data_in, Q <= Data_in, TC <= 0.
  - Next state = RUN if Data_in != 0; IDLE if Data_in == 0.
  - A load mid-run restarts the count and never produces TC on that edge.
- RUN, Count_en = 0: Q and state hold, TC <= 0.
- RUN, Count_en = 1, Q > 1: Q <= Q - 1, TC <= 0.
- RUN, Count_en = 1, Q == 1 (expiry edge): TC <= 1, Irq <= 1.
  - Mode = 1: Q <= Reload, stay in RUN. Period = Reload enabled cycles. Reload = 1 gives TC on every enabled cycle.
  - Mode = 0: Q <= 0, state -> DONE.
  - Mode is sampled only on the expiry edge.
- IDLE and DONE: Q holds, TC <= 0, Count_en and Mode are ignored. These states are left only via Load_en or RST.
- No wrap-around: Q never decrements below 0 and never wraps to 2^N - 1.
- Data_in = 2^N - 1 is valid and gives the maximum period.
- TC timing: high exactly in the cycle in which Q first shows the post-expiry value (0 or Reload). Latency from load to TC = Data_in enabled edges.
- Irq:
  - Set on any edge where TC is set.
  - Cleared by Irq_clr when no TC is being set on the same edge.
  - Simultaneous set and clear: set wins, Irq stays 1.
  - Irq_clr with Irq = 0 has no effect.
- Reset mid-operation: RST = 1 on any edge forces all reset values, including Reload and Irq, regardless of Load_en, Count_en or a pending expiry.
- Arithmetic: unsigned, N bits. The compare Q == 1 is a full-width compare.

Test Plan:
1. Reset: hold RST = 1 two cycles with Load_en = 1, Data_in = 8'h10 -> Q = 0, TC = 0, Irq = 0, Running = 0, Done = 0 after the edge.
2. One-shot: load 5, Mode = 0, Count_en = 1 -> Q = 5, 4, 3, 2, 1, 0 on successive cycles. TC = 1 only in the cycle Q = 0. Done = 1, Running = 0, Irq = 1. Q stays 0 for 10 more cycles with no further TC.
3. Periodic with clear: load 3, Mode = 1 -> Q = 3, 2, 1, 3, 2, 1, 3. TC on each Q = 3 reload cycle. Pulse Irq_clr on the same edge TC is set -> Irq stays 1. Pulse Irq_clr one cycle later -> Irq = 0.
4. Pause and reload-of-one: in periodic mode at Q = 2, drop Count_en for 4 cycles -> Q = 2 held, no TC. Then load 1, Mode = 1 -> TC high every enabled cycle, Q constant 1.
5. Load mid-run: at Q = 2 load 8'hFF -> Q = 8'hFF next cycle, no TC, Running = 1. Then load 0 -> Q = 0, state IDLE, no TC, Irq unchanged.
6. Reset mid-run: Irq = 1, Q = 7, Mode = 1, assert RST with Load_en = 1 -> next cycle all outputs at reset values. Count_en = 1 afterwards -> Q stays 0, no TC.
